// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state for the sequential ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_AND    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_XOR    = 5'h04;
    localparam logic [4:0] OP_NOT    = 5'h05;
    localparam logic [4:0] OP_LSL1   = 5'h06;
    localparam logic [4:0] OP_LSR1   = 5'h07;
    localparam logic [4:0] OP_ASR1   = 5'h08;
    localparam logic [4:0] OP_INC    = 5'h09;
    localparam logic [4:0] OP_DEC    = 5'h0A;
    localparam logic [4:0] OP_EQ     = 5'h0B;
    localparam logic [4:0] OP_LT     = 5'h0C;
    localparam logic [4:0] OP_GT     = 5'h0D;
    localparam logic [4:0] OP_GE     = 5'h0E;
    localparam logic [4:0] OP_LE     = 5'h0F;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_SATADD = 5'h11;
    localparam logic [4:0] OP_SATSUB = 5'h12;

    localparam int FLAG_COUT  = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_EQUAL = 4;

    typedef enum logic {IDLE, MUL} state_t;

    function automatic logic is_reserved(input logic [4:0] op);
        return op > OP_SATSUB;
    endfunction

    function automatic logic [4:0] pack_flags(input logic equal, input logic neg,
                                              input logic ovf, input logic zero,
                                              input logic cout);
        logic [4:0] f;
        f             = '0;
        f[FLAG_EQUAL] = equal;
        f[FLAG_NEG]   = neg;
        f[FLAG_OVF]   = ovf;
        f[FLAG_ZERO]  = zero;
        f[FLAG_COUT]  = cout;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: arithmetic, logic, shifts, compares, saturation.
module alu_core import alu_pkg::*; #(
    parameter int N = 8
) (
    input  logic [4:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [4:0]   flags
);

    localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};
    localparam logic [N:0]   ONE  = {{N{1'b0}}, 1'b1};

    logic [N:0] add_w, sub_w, inc_w, dec_w;
    logic       cout, ovf, equal;

    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};
    assign inc_w = {1'b0, a} + ONE;
    assign dec_w = {1'b0, a} - ONE;

    always_comb begin
        result = '0;
        cout   = 1'b0;
        ovf    = 1'b0;
        equal  = 1'b0;
        case (op)
            OP_ADD: begin
                {cout, result} = add_w;
                ovf = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
            end
            OP_SUB: begin
                {cout, result} = sub_w;
                ovf = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_LSL1: result = {a[N-2:0], 1'b0};
            OP_LSR1: result = {1'b0, a[N-1:1]};
            OP_ASR1: result = {a[N-1], a[N-1:1]};
            OP_INC: begin
                {cout, result} = inc_w;
                ovf = !a[N-1] && inc_w[N-1];
            end
            OP_DEC: begin
                {cout, result} = dec_w;
                ovf = a[N-1] && !dec_w[N-1];
            end
            OP_EQ: begin
                equal  = (a == b);
                result = {{(N-1){1'b0}}, a == b};
            end
            OP_LT: result = {{(N-1){1'b0}}, a <  b};
            OP_GT: result = {{(N-1){1'b0}}, a >  b};
            OP_GE: result = {{(N-1){1'b0}}, a >= b};
            OP_LE: result = {{(N-1){1'b0}}, a <= b};
            // Saturating ops clamp toward the sign of A, the only sign an overflow can take.
            OP_SATADD: begin
                ovf    = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
                result = ovf ? (a[N-1] ? SMIN : SMAX) : add_w[N-1:0];
            end
            OP_SATSUB: begin
                ovf    = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
                result = ovf ? (a[N-1] ? SMIN : SMAX) : sub_w[N-1:0];
            end
            default: result = '0;
        endcase
    end

    assign flags = pack_flags(equal, result[N-1], ovf, result == '0, cout);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready front end, shift-add multiplier FSM, accumulator and sticky status.
module alu_seq import alu_pkg::*; #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         use_acc,
    input  logic         sticky_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic [4:0]   flags,
    output logic [1:0]   sticky,
    output logic [N-1:0] acc,
    output logic         busy
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Handshake: a transfer happens on any rising edge where valid and ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.
    state_t        state;
    logic          accept, mul_done;
    logic [N-1:0]  op_a, core_res;
    logic [4:0]    core_flags, mul_flags;
    logic [N-1:0]  mul_a, mul_hi, mul_lo, next_hi, next_lo;
    logic [CW-1:0] mul_cnt;
    logic [N:0]    mul_sum;
    logic [1:0]    sticky_set;

    assign op_a     = use_acc ? acc : a;
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign mul_done = (state == MUL) && (mul_cnt == LAST);

    alu_core #(.N(N)) u_core (
        .op     (op),
        .a      (op_a),
        .b      (b),
        .result (core_res),
        .flags  (core_flags)
    );

    // One shift-add step per cycle: product high half in mul_hi, multiplier shifts out of mul_lo.
    assign mul_sum   = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : {(N+1){1'b0}});
    assign next_hi   = mul_sum[N:1];
    assign next_lo   = {mul_sum[0], mul_lo[N-1:1]};
    assign mul_flags = pack_flags(1'b0, next_hi[N-1], next_hi != '0,
                                  {next_hi, next_lo} == '0, 1'b0);

    always_comb begin
        sticky_set = 2'b00;
        if (accept && op != OP_MUL)
            sticky_set = {core_flags[FLAG_OVF], core_flags[FLAG_COUT]};
        else if (mul_done)
            sticky_set = {mul_flags[FLAG_OVF], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
            sticky    <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            mul_a     <= '0;
            mul_hi    <= '0;
            mul_lo    <= '0;
            mul_cnt   <= '0;
        end else begin
            sticky <= (sticky_clr ? 2'b00 : sticky) | sticky_set;
            case (state)
                IDLE: begin
                    if (accept && op == OP_MUL) begin
                        state     <= MUL;
                        busy      <= 1'b1;
                        out_valid <= 1'b0;
                        mul_a     <= op_a;
                        mul_lo    <= b;
                        mul_hi    <= '0;
                        mul_cnt   <= '0;
                    end else if (accept) begin
                        result    <= core_res;
                        result_hi <= '0;
                        flags     <= core_flags;
                        out_valid <= 1'b1;
                        if (!is_reserved(op))
                            acc <= core_res;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    mul_hi  <= next_hi;
                    mul_lo  <= next_lo;
                    mul_cnt <= mul_cnt + CW'(1);
                    if (mul_done) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        result    <= next_lo;
                        result_hi <= next_hi;
                        flags     <= mul_flags;
                        out_valid <= 1'b1;
                        acc       <= next_lo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq (N=8) against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int N = 8;

    logic         clk, rst_n;
    logic         in_valid, in_ready, use_acc, sticky_clr;
    logic [4:0]   op;
    logic [N-1:0] a, b;
    logic         out_valid, out_ready, busy;
    logic [N-1:0] result, result_hi, acc;
    logic [4:0]   flags;
    logic [1:0]   sticky;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_acc;
    logic [1:0] m_sticky;

    alu_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .use_acc    (use_acc),
        .sticky_clr (sticky_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_hi  (result_hi),
        .flags      (flags),
        .sticky     (sticky),
        .acc        (acc),
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t, required completion earlier", $time);
        $fatal(1, "watchdog");
    end

    // reference model: plain integer arithmetic on the opcode definitions
    function automatic void model(input logic [4:0] o, input int ua, input int ub,
                                  output int res, output int hi,
                                  output logic [4:0] fl, output bit acc_wr);
        int sa, sb, full;
        bit c, v, e, z, ng;
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        c = 0; v = 0; e = 0; hi = 0; acc_wr = 1; full = 0;
        case (int'(o))
            0:  begin full = ua + ub; res = full & 255; c = full > 255; v = (sa + sb > 127) || (sa + sb < -128); end
            1:  begin full = ua - ub; res = full & 255; c = full < 0;   v = (sa - sb > 127) || (sa - sb < -128); end
            2:  res = ua & ub;
            3:  res = ua | ub;
            4:  res = ua ^ ub;
            5:  res = 255 - ua;
            6:  res = (ua * 2) % 256;
            7:  res = ua / 2;
            8:  res = (sa >>> 1) & 255;
            9:  begin full = ua + 1; res = full & 255; c = full > 255; v = (sa + 1 > 127); end
            10: begin full = ua - 1; res = full & 255; c = full < 0;   v = (sa - 1 < -128); end
            11: begin res = (ua == ub) ? 1 : 0; e = (ua == ub); end
            12: res = (ua <  ub) ? 1 : 0;
            13: res = (ua >  ub) ? 1 : 0;
            14: res = (ua >= ub) ? 1 : 0;
            15: res = (ua <= ub) ? 1 : 0;
            16: begin full = ua * ub; res = full % 256; hi = full / 256; v = (hi != 0); end
            17: begin full = sa + sb;
                      if (full > 127) begin res = 127; v = 1; end
                      else if (full < -128) begin res = 128; v = 1; end
                      else res = full & 255; end
            18: begin full = sa - sb;
                      if (full > 127) begin res = 127; v = 1; end
                      else if (full < -128) begin res = 128; v = 1; end
                      else res = full & 255; end
            default: begin res = 0; acc_wr = 0; end
        endcase
        if (int'(o) == 16) begin z = (full == 0); ng = (hi >= 128); end
        else begin z = (res == 0); ng = (res >= 128); end
        fl = {e, ng, v, z, c};
    endfunction

    // driver tasks
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [4:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input logic ua, input logic cl);
        int n;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = av; b = bv; use_acc = ua; sticky_clr = cl;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL issue_timeout in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; sticky_clr = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        @(posedge clk); #1;
        vectors++; if ({out_valid, busy, result, result_hi, flags, sticky, acc} !== '0) begin
            miscompares++; $display("FAIL reset_outputs got ov=%b busy=%b res=%h hi=%h fl=%b st=%b acc=%h, required all 0",
                                    out_valid, busy, result, result_hi, flags, sticky, acc); end
        vectors++; if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready got %b, required 1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add_ovf();
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        vectors++; if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL add_latency out_valid=%b, required 1", out_valid); end
        vectors++; if (result !== 8'h80 || result_hi !== 8'h00) begin
            miscompares++; $display("FAIL add_result got %h/%h, required 00/80", result_hi, result); end
        vectors++; if (flags !== 5'b01100) begin
            miscompares++; $display("FAIL add_flags got %b, required 01100", flags); end
        vectors++; if (sticky !== 2'b10) begin
            miscompares++; $display("FAIL add_sticky got %b, required 10", sticky); end
    endtask

    task automatic test_mul();
        issue(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0);
        a = 8'h00; b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            vectors++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++; $display("FAIL mul_busy cycle %0d busy=%b in_ready=%b out_valid=%b, required 1/0/0",
                                        i + 1, busy, in_ready, out_valid); end
            @(posedge clk); #1;
        end
        vectors++; if (out_valid !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL mul_done cycle 9 out_valid=%b busy=%b, required 1/0", out_valid, busy); end
        vectors++; if (result !== 8'h01 || result_hi !== 8'hFE) begin
            miscompares++; $display("FAIL mul_product got %h%h, required FE01", result_hi, result); end
        vectors++; if (flags !== 5'b01100 || acc !== 8'h01) begin
            miscompares++; $display("FAIL mul_flags_acc got fl=%b acc=%h, required 01100/01", flags, acc); end
    endtask

    task automatic test_saturate();
        issue(OP_SATADD, 8'h70, 8'h20, 1'b0, 1'b0);
        vectors++; if (result !== 8'h7F || flags !== 5'b00100) begin
            miscompares++; $display("FAIL satadd got %h fl=%b, required 7F fl=00100", result, flags); end
        issue(OP_SATSUB, 8'h80, 8'h01, 1'b0, 1'b0);
        vectors++; if (result !== 8'h80 || flags !== 5'b01100) begin
            miscompares++; $display("FAIL satsub got %h fl=%b, required 80 fl=01100", result, flags); end
        issue(OP_SUB, 8'h00, 8'h01, 1'b0, 1'b0);
        vectors++; if (result !== 8'hFF || flags !== 5'b01001) begin
            miscompares++; $display("FAIL sub_borrow got %h fl=%b, required FF fl=01001", result, flags); end
        vectors++; if (sticky !== 2'b11) begin
            miscompares++; $display("FAIL sub_sticky got %b, required 11", sticky); end
    endtask

    task automatic test_backpressure();
        @(negedge clk); @(negedge clk);
        in_valid = 1'b1; op = OP_AND; a = 8'h3C; b = 8'h0F; use_acc = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        op = OP_XOR; a = 8'hAA; b = 8'h55;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_valid !== 1'b1 || result !== 8'h0C || in_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_hold cycle %0d ov=%b res=%h in_ready=%b, required 1/0C/0",
                                        i, out_valid, result, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || result !== 8'hFF) begin
            miscompares++; $display("FAIL bp_release ov=%b res=%h, required 1/FF", out_valid, result); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_single_accept out_valid=%b, required 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; op = OP_OR; a = 8'h05; b = 8'h00; use_acc = 1'b0;
        @(posedge clk); #1;
        vectors++; if (result !== 8'h05) begin
            miscompares++; $display("FAIL b2b_or got %h, required 05", result); end
        op = OP_INC; a = 8'hEE; use_acc = 1'b1;
        @(posedge clk); #1;
        vectors++; if (result !== 8'h06 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL b2b_inc1 got %h ov=%b, required 06/1", result, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0; use_acc = 1'b0;
        vectors++; if (result !== 8'h07 || acc !== 8'h07) begin
            miscompares++; $display("FAIL b2b_inc2 got res=%h acc=%h, required 07/07", result, acc); end
    endtask

    task automatic test_reset_mid_mul();
        issue(OP_MUL, 8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || acc !== 8'h00 || sticky !== 2'b00 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_mul ov=%b acc=%h st=%b busy=%b, required 0/00/00/0",
                                    out_valid, acc, sticky, busy); end
        vectors++; if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_mul_ready got %b, required 1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_no_result ov=%b in_ready=%b, required 0/1", out_valid, in_ready); end
        issue(OP_SUB, 8'h00, 8'h01, 1'b0, 1'b0);
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b1);
        vectors++; if (sticky !== 2'b10) begin
            miscompares++; $display("FAIL sticky_clr_set got %b, required 10", sticky); end
    endtask

    task automatic test_random();
        logic [4:0] o;
        logic [7:0] av, bv, opa;
        logic       ua, cl;
        logic [4:0] e_fl;
        int         e_res, e_hi, e_lat, lat;
        bit         e_wr;
        apply_reset();
        m_acc = 8'h00; m_sticky = 2'b00;
        for (int i = 0; i < 80; i++) begin
            o  = ($urandom_range(0, 3) == 0) ? OP_MUL : 5'($urandom_range(0, 31));
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            ua = 1'($urandom_range(0, 1));
            cl = ($urandom_range(0, 7) == 0);
            opa = ua ? m_acc : av;
            model(o, int'(opa), int'(bv), e_res, e_hi, e_fl, e_wr);
            m_sticky = (cl ? 2'b00 : m_sticky) | {e_fl[2], e_fl[0]};
            if (e_wr) m_acc = 8'(e_res);
            e_lat = (o == OP_MUL) ? 8 : 0;
            issue(o, av, bv, ua, cl);
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            vectors++; if (lat !== e_lat) begin
                miscompares++; $display("FAIL rnd_latency op=%h got %0d, required %0d", o, lat, e_lat); end
            vectors++; if (result !== 8'(e_res) || result_hi !== 8'(e_hi)) begin
                miscompares++; $display("FAIL rnd_result op=%h a=%h b=%h got %h%h, required %h%h",
                                        o, opa, bv, result_hi, result, 8'(e_hi), 8'(e_res)); end
            vectors++; if (flags !== e_fl) begin
                miscompares++; $display("FAIL rnd_flags op=%h a=%h b=%h got %b, required %b", o, opa, bv, flags, e_fl); end
            vectors++; if (acc !== m_acc || sticky !== m_sticky) begin
                miscompares++; $display("FAIL rnd_state op=%h got acc=%h st=%b, required %h/%b",
                                        o, acc, sticky, m_acc, m_sticky); end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
        use_acc = 1'b0; sticky_clr = 1'b0; out_ready = 1'b1;
        test_reset();
        test_add_ovf();
        test_mul();
        test_saturate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
